// File: rtl/one_hot_seq.sv
// N-position sequencer with registered count and one-hot decode, direction control,
// wrap/one-shot termination and parallel load. Optional self-check: ONE_HOT_SEQ_CHECK_EN.
module one_hot_seq #(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          go,
  input  logic          dir,
  input  logic          wrap_en,
  input  logic          load,
  input  logic [CW-1:0] load_idx,
  output logic [CW-1:0] count,
  output logic [N-1:0]  one_hot1,
  output logic          busy,
  output logic          done
`ifdef ONE_HOT_SEQ_CHECK_EN
  ,
  output logic          onehot_err
`endif
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_step;
  logic [CW-1:0] w_load_clamped;
  logic [N-1:0]  r_one_hot;
  logic [N-1:0]  w_one_hot_next;
  logic          r_done;
  logic          w_done_next;
  logic          w_at_term;

  // State register, with count/decode/done registered on the same edge
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_one_hot <= N'(1);
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_one_hot <= w_one_hot_next;
      r_done    <= w_done_next;
    end
  end

  // Terminal position and step arithmetic wrap modulo N, not modulo 2**CW
  always_comb begin
    w_at_term = dir ? (r_count == '0) : (r_count == LAST);
    if (dir) begin
      w_step = (r_count == '0) ? LAST : (r_count - ONE);
    end else begin
      w_step = (r_count == LAST) ? '0 : (r_count + ONE);
    end
    w_load_clamped = (load_idx > LAST) ? LAST : load_idx;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (load) begin
      w_state_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (go) w_state_next = S_RUN;
        S_RUN:   if (go && w_at_term && !wrap_en) w_state_next = S_DONE;
        S_DONE:  if (!go) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Datapath next values; a one-shot terminal step holds count but still pulses done
  always_comb begin
    w_count_next = r_count;
    w_done_next  = 1'b0;
    if (load) begin
      w_count_next = w_load_clamped;
    end else if (r_state == S_RUN && go) begin
      w_done_next = w_at_term;
      if (!(w_at_term && !wrap_en)) begin
        w_count_next = w_step;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_decode
      assign w_one_hot_next[gi] = (w_count_next == CW'(gi));
    end
  endgenerate

  // Output logic
  always_comb begin
    busy     = (r_state == S_RUN);
    count    = r_count;
    one_hot1 = r_one_hot;
    done     = r_done;
  end

`ifdef ONE_HOT_SEQ_CHECK_EN
  logic [N-1:0] w_dec_now;
  logic         w_not_onehot;
  logic         w_mismatch;
  logic         r_onehot_err;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_check_dec
      assign w_dec_now[gi] = (r_count == CW'(gi));
    end
  endgenerate

  always_comb begin
    w_not_onehot = (r_one_hot == '0) || ((r_one_hot & (r_one_hot - N'(1))) != '0);
    w_mismatch   = (r_one_hot != w_dec_now) || w_not_onehot;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_onehot_err <= 1'b0;
    end else if (w_mismatch) begin
      r_onehot_err <= 1'b1;
    end
  end

  assign onehot_err = r_onehot_err;
`endif

endmodule

// File: doc/one_hot_seq.md
Name: one_hot_seq

Overview:
Parametrised one-hot position sequencer: an N-position counter with a registered one-hot decode of the current position.
Adds direction control, wrap or one-shot termination, parallel load, a busy flag and a terminal-position done pulse.
Drives per-lane/per-slot enables in the PCIe datapath, where N exceeds 8 or a sweep must stop at its last slot.

Parameters:
N, 8, number of positions / one-hot output width; legal range 2..256.
CW, 3, count width; must satisfy 2**CW >= N. The default pair (8, 3) reproduces the existing 3-bit/8-way decode.

Ports:
clk  input  1  rising-edge clock
nreset  input  1  reset, synchronous, active-low
go  input  1  advance enable / start request
dir  input  1  0 = step up, 1 = step down
wrap_en  input  1  1 = wrap at terminal position, 0 = one-shot (stop at terminal)
load  input  1  parallel load strobe
load_idx  input  CW  position to load
count  output  CW  current position, registered
one_hot1  output  N  one_hot1[count] = 1, all other bits 0, registered
busy  output  1  high while state = RUN
done  output  1  one-cycle pulse on terminal step

Behaviour:
- Clock and reset: single clock clk; reset nreset is synchronous and active-low.
- Reset (nreset = 0 at a clk edge): state = IDLE, count = 0, one_hot1 = 1 (bit 0 set), busy = 0, done = 0. Reset applies mid-RUN or mid-DONE with no residual pulse.
- Priority per cycle: nreset > load > stepping.
- count and one_hot1 are both registered and update on the same edge; they never disagree.
- Terminal position: N-1 when dir = 0, 0 when dir = 1.
- Stepping arithmetic: modulo N, not modulo 2**CW. Up from N-1 wraps to 0; down from 0 wraps to N-1.
- State machine (states IDLE, RUN, DONE):
  - IDLE: busy = 0, count held. go = 1 moves to RUN; no step on that edge.
  - RUN: busy = 1.
    - go = 0: count held (pause); state stays RUN.
    - go = 1, count not at terminal: count steps by one in direction dir.
    - go = 1, count at terminal, wrap_en = 1: count wraps, done = 1 for one cycle, state stays RUN.
    - go = 1, count at terminal, wrap_en = 0: count held at terminal, done = 1 for one cycle, state goes to DONE.
  - DONE: busy = 0, count held. Leaves to IDLE only once go = 0 is sampled, so a held go never retriggers.
- done is registered and asserts on the same edge that shows the post-step count. It deasserts on the next edge.
- dir and wrap_en are sampled every cycle. Changing dir mid-RUN takes effect on the next step; the terminal position is re-evaluated with the new dir.
- load = 1 (any state):
  - count = load_idx if load_idx <= N-1, else count = N-1 (clamp).
  - State goes to IDLE, done = 0, busy = 0 on the next cycle.
  - load with go = 1 in the same cycle: the load wins, no step occurs.
- Loading the terminal position then running: the first go step is a terminal step (done pulse, plus wrap or stop per wrap_en).
- N not a power of two: positions N..2**CW-1 are unreachable. one_hot1 never has a bit at or above N.

Optional Feature:
Macro ONE_HOT_SEQ_CHECK_EN.
- Defined:
  - Adds output port onehot_err (1 bit).
  - Each cycle, one_hot1 is compared with a combinational decode of count; onehot_err is also set if one_hot1 is not exactly one-hot.
  - onehot_err is sticky: set on the cycle after a mismatch, cleared only by nreset.
  - The check logic sits beside the main registers and does not alter them.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then N=8, dir=0, wrap_en=1, go held high -> count 0,1..7,0 (first step one cycle after go), one_hot1 0x01..0x80,0x01; done high exactly on the edge count returns to 0; busy=1 throughout.
2. N=8, dir=0, wrap_en=0, go held high -> count stops at 7 with one_hot1=0x80; one done pulse; state DONE, busy=0; count stays 7 while go is still high; go=0 then go=1 -> IDLE, then RUN.
3. N=5, CW=3, dir=1, wrap_en=1 from count 0 -> next steps give count 4,3,2,1,0,4; done pulses on the step to 4; one_hot1[7:5] always 0.
4. load=1, load_idx=6 with N=5 -> count=4 (clamped), one_hot1=0x10, state IDLE; load and go together in RUN -> load wins, no step, no done.
5. go toggled 1,0,0,1 in RUN -> count advances only on go=1 cycles; nreset=0 asserted mid-RUN at count 3 -> next edge count=0, one_hot1=1, busy=0, done=0.
6. With ONE_HOT_SEQ_CHECK_EN: force one_hot1 to 0x03 for one cycle -> onehot_err=1 from the next cycle, held until nreset; without the macro, the port is absent and compiles clean.
